// File: rtl/snap_capture_sequencer_if.sv
// Snapshot BRAM write port: one registered address/data/enable triple per cycle.
// The sequencer drives it as master; the BRAM side (or a bench) listens as slave.
interface snap_capture_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;

    modport master (output bram_addr, output bram_data, output bram_we);
    modport slave  (input  bram_addr, input  bram_data, input  bram_we);
endinterface

// File: rtl/snap_capture_sequencer.sv
// Arms from the software control word, optionally waits for an external trigger, then
// writes a fixed-length burst of ADC samples into the snapshot BRAM and reports status.
module snap_capture_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int NSAMP  = 1024
) (
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    input  logic [31:0]             ctrl_in,
    input  logic [DATA_W-1:0]       din,
    input  logic                    we_in,
    input  logic                    trig_in,
    snap_capture_sequencer_if.master bram,
    output logic [31:0]             status_out,
    output logic                    busy
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSAMP - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_CAPTURE, S_DONE} state_t;

    state_t            state, state_nxt;
    logic              arm_q;
    logic              arm_ok;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              we_nxt;
    logic [31:0]       status_nxt;

    logic arm_edge, trig_sel, abort, wq, last_write, unused_ctrl;

    assign trig_sel    = ctrl_in[1];
    assign abort       = ctrl_in[3];
    assign wq          = ~ctrl_in[2] | we_in;
    assign unused_ctrl = ^ctrl_in[31:4];

    // arm_ok keeps an arm bit that was already high across reset from looking like a new edge.
    assign arm_edge   = ctrl_in[0] & ~arm_q & arm_ok;
    assign last_write = wq && (count == LAST);

    assign busy = (state == S_WAIT_TRIG) || (state == S_CAPTURE);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (!abort && arm_edge) state_nxt = trig_sel ? S_WAIT_TRIG : S_CAPTURE;
            end
            S_WAIT_TRIG: begin
                if (abort)        state_nxt = S_IDLE;
                else if (trig_in) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort)           state_nxt = S_IDLE;
                else if (last_write) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        we_nxt    = 1'b0;
        addr_nxt  = bram.bram_addr;
        data_nxt  = bram.bram_data;
        count_nxt = count;
        case (state)
            S_IDLE, S_DONE: begin
                if (!abort && arm_edge) count_nxt = '0;
            end
            S_CAPTURE: begin
                // Abort wins over the write, including the final one.
                if (!abort && wq) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = count[ADDR_W-1:0];
                    data_nxt  = din;
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: ;
        endcase

        status_nxt            = '0;
        status_nxt[31]        = (state == S_DONE);
        status_nxt[30]        = busy;
        status_nxt[29]        = (state == S_WAIT_TRIG);
        status_nxt[ADDR_W:0]  = count;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            arm_q          <= 1'b0;
            arm_ok         <= 1'b0;
            count          <= '0;
            bram.bram_we   <= 1'b0;
            bram.bram_addr <= '0;
            bram.bram_data <= '0;
            status_out     <= '0;
        end else begin
            arm_q          <= ctrl_in[0];
            if (!ctrl_in[0]) arm_ok <= 1'b1;
            count          <= count_nxt;
            bram.bram_we   <= we_nxt;
            bram.bram_addr <= addr_nxt;
            bram.bram_data <= data_nxt;
            status_out     <= status_nxt;
        end
    end
endmodule

// File: tb/tb_snap_capture_sequencer.sv
// Directed bench: expected BRAM writes are queued as stimulus is driven and checked as they appear.
module tb_snap_capture_sequencer;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam int NSAMP  = 8;

    logic              user_clk = 1'b0;
    logic              user_rst_n = 1'b0;
    logic [31:0]       ctrl_in;
    logic [DATA_W-1:0] din;
    logic              we_in, trig_in;
    logic [31:0]       status_out;
    logic              busy;

    always #5 user_clk = ~user_clk;

    snap_capture_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    snap_capture_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSAMP(NSAMP)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctrl_in    (ctrl_in),
        .din        (din),
        .we_in      (we_in),
        .trig_in    (trig_in),
        .bram       (bus),
        .status_out (status_out),
        .busy       (busy)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               sb[$];
    int                n_cmp = 0;
    int                n_err = 0;
    logic [ADDR_W-1:0] exp_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; w says whether the sample on din this cycle must land in BRAM.
    task automatic step(input bit w);
        if (w) begin
            sb.push_back(wr_t'{addr: exp_addr, data: din});
            exp_addr++;
        end
        @(posedge user_clk);
        #1;
        din = din + 1;
    endtask

    always @(negedge user_clk) begin
        wr_t e;
        if (bus.bram_we) begin
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("write_addr", 64'(bus.bram_addr), 64'(e.addr));
                chk("write_data", 64'(bus.bram_data), 64'(e.data));
            end
        end
    end

    initial begin
        ctrl_in = '0; din = '0; we_in = 1'b0; trig_in = 1'b0; exp_addr = '0;
        #12;
        chk("rst_we", 64'(bus.bram_we), 64'd0);
        chk("rst_addr", 64'(bus.bram_addr), 64'd0);
        chk("rst_data", 64'(bus.bram_data), 64'd0);
        chk("rst_status", 64'(status_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        user_rst_n = 1'b1;
        step(0); step(0);

        // immediate capture, ramp data
        ctrl_in = 32'h1; exp_addr = '0;
        step(0);
        chk("t1_busy", 64'(busy), 64'd1);
        repeat (8) step(1);
        chk("t1_idle_busy", 64'(busy), 64'd0);
        step(0);
        chk("t1_status", 64'(status_out), 64'h8000_0008);
        chk("t1_drained", 64'(sb.size()), 64'd0);

        // triggered capture; trigger in the arm cycle is ignored
        ctrl_in = 32'h0; step(0);
        ctrl_in = 32'h3; trig_in = 1'b1;
        step(0);
        trig_in = 1'b0;
        step(0);
        chk("t2_waiting", 64'(status_out), 64'h6000_0000);
        chk("t2_busy", 64'(busy), 64'd1);
        repeat (3) step(0);
        trig_in = 1'b1;
        step(0);
        trig_in = 1'b0; exp_addr = '0;
        repeat (8) step(1);
        step(0);
        chk("t2_status", 64'(status_out), 64'h8000_0008);
        chk("t2_drained", 64'(sb.size()), 64'd0);

        // qualified writes, we_in toggling
        ctrl_in = 32'h0; step(0);
        ctrl_in = 32'h5; we_in = 1'b1;
        step(0);
        exp_addr = '0;
        for (int i = 0; i < 15; i++) begin
            we_in = (i % 2 == 0);
            step(we_in);
        end
        we_in = 1'b0;
        step(0);
        chk("t3_status", 64'(status_out), 64'h8000_0008);
        chk("t3_drained", 64'(sb.size()), 64'd0);

        // abort at count 3, then abort blocking an arm edge, then restart from 0
        ctrl_in = 32'h0; step(0);
        ctrl_in = 32'h1; step(0);
        exp_addr = '0;
        repeat (3) step(1);
        ctrl_in = 32'h9;
        step(0);
        chk("t4_abort_busy", 64'(busy), 64'd0);
        ctrl_in = 32'h0;
        step(0);
        chk("t4_status", 64'(status_out), 64'h0000_0003);
        ctrl_in = 32'h9;
        step(0);
        chk("t4_blocked", 64'(busy), 64'd0);
        ctrl_in = 32'h0; step(0);
        ctrl_in = 32'h1; step(0);
        chk("t4_rearm", 64'(busy), 64'd1);
        exp_addr = '0;
        repeat (8) step(1);
        step(0);
        chk("t4_status_done", 64'(status_out), 64'h8000_0008);

        // arm held through DONE: no restart; fresh edge restarts and clears done
        repeat (3) step(0);
        chk("t5_held_status", 64'(status_out), 64'h8000_0008);
        chk("t5_held_busy", 64'(busy), 64'd0);
        ctrl_in = 32'h0; step(0);
        ctrl_in = 32'h1; step(0);
        chk("t5_busy", 64'(busy), 64'd1);
        exp_addr = '0;
        step(1);
        chk("t5_status", 64'(status_out), 64'h4000_0000);
        repeat (2) step(1);

        // async reset mid-capture with arm held high
        @(negedge user_clk);
        #1;
        user_rst_n = 1'b0;
        #1;
        chk("t6_rst_we", 64'(bus.bram_we), 64'd0);
        chk("t6_rst_status", 64'(status_out), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_drained", 64'(sb.size()), 64'd0);
        #20;
        user_rst_n = 1'b1;
        repeat (3) step(0);
        chk("t6_no_arm_busy", 64'(busy), 64'd0);
        chk("t6_no_arm_status", 64'(status_out), 64'd0);
        ctrl_in = 32'h0; step(0);
        ctrl_in = 32'h1; step(0);
        chk("t6_rearm", 64'(busy), 64'd1);
        exp_addr = '0;
        repeat (8) step(1);
        step(0);
        chk("t6_status", 64'(status_out), 64'h8000_0008);
        chk("t6_final_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/snap_capture_sequencer.md
Name: snap_capture_sequencer

Overview:
- Sequences one ADC snapshot capture into the snapshot BRAM.
- Control comes from the 32-bit software control word; the PPC-to-fabric control register drives it, already in the user_clk domain.
- Flow: arm, optionally wait for an external trigger, write a fixed-length burst of samples with optional per-sample write qualification, then report done and the sample count back to software.
- Sits between the control register, the ADC sample stream and the snapshot BRAM write port.

Parameters:
- ADDR_W, 10, BRAM address width.
- DATA_W, 32, sample and BRAM data width.
- NSAMP, 1024, samples per capture; must satisfy 1 <= NSAMP <= 2^ADDR_W.

Ports:
- user_clk  in  1  fabric clock; all logic is on its rising edge.
- user_rst_n  in  1  asynchronous, active-low reset.
- ctrl_in  in  32  software control word.
  - bit0 arm.
  - bit1 trig_sel: 0 = immediate, 1 = external trigger.
  - bit2 we_sel: 0 = write every cycle, 1 = write only when we_in is high.
  - bit3 abort.
  - Other bits ignored.
- din  in  DATA_W  ADC sample stream.
- we_in  in  1  per-sample write qualifier.
- trig_in  in  1  external trigger, synchronous to user_clk, level-sampled.
- bram_addr  out  ADDR_W  BRAM write address (registered).
- bram_data  out  DATA_W  BRAM write data (registered).
- bram_we  out  1  BRAM write enable (registered).
- status_out  out  32  status word for the ppc-readable register.
  - [31] done.
  - [30] busy.
  - [29] waiting.
  - [ADDR_W:0] samples written.
  - Other bits 0.
- busy  out  1  high in WAIT_TRIG or CAPTURE.

Behaviour:
- Reset: all outputs 0, state IDLE, count 0, arm_q 0.
- arm_q is the registered ctrl_in[0]; arm_edge = ctrl_in[0] & ~arm_q. Holding arm high never re-arms.
- Write qualifier: wq = (we_sel==0) | we_in. trig_sel and we_sel are sampled live every cycle.
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- IDLE or DONE, on arm_edge:
  - count := 0 and done := 0.
  - Next state CAPTURE if trig_sel==0, else WAIT_TRIG.
  - No BRAM write occurs in the arm cycle.
- WAIT_TRIG:
  - trig_in==1 moves to CAPTURE next cycle.
  - The trigger cycle's sample is not written.
  - A trigger coincident with the arm_edge cycle is ignored; the block waits for trig_in to be sampled in WAIT_TRIG.
- CAPTURE, each cycle with wq==1:
  - Registers bram_we=1, bram_addr=count[ADDR_W-1:0], bram_data=din. They appear one cycle after the sample.
  - count increments.
  - When count==NSAMP-1 at such a write, the next state is DONE.
- CAPTURE with wq==0: bram_we=0; count, addr and data hold.
- bram_we is 0 in every state other than CAPTURE.
- DONE: done=1, count held at NSAMP. Stays in DONE until the next arm_edge.
- Abort (ctrl_in[3]==1) in WAIT_TRIG or CAPTURE:
  - Next state IDLE, done=0, count keeps its value.
  - bram_we is not asserted in the abort cycle.
  - Abort has priority over trigger and over the final write.
  - In IDLE/DONE, abort blocks arm_edge while high.
- arm_edge in WAIT_TRIG or CAPTURE is ignored (no restart). arm_q still tracks ctrl_in[0].
- Count width is ADDR_W+1 so that NSAMP=2^ADDR_W reports without wrap. Addresses never wrap within one capture.
- status_out is registered:
  - busy = state is WAIT_TRIG or CAPTURE.
  - waiting = state is WAIT_TRIG.
  - Status updates one cycle after the state change.
- Asynchronous reset mid-capture: immediate return to reset values. A partial BRAM content is left as-is.

Test Plan:
- Immediate capture, NSAMP=8, trig_sel=0, we_sel=0, ramp din=0,1,2,…: arm rises → 8 consecutive bram_we pulses, addr 0..7, data equal to the ramp sample one cycle earlier. Then status_out[31]=1, [30]=0, count=8.
- Triggered capture, trig_sel=1: arm, then trig_in high 5 cycles later → waiting=1 until the trigger; first write at addr 0 is the sample after the trigger cycle; 8 writes, then done.
- Qualified writes, we_sel=1, we_in toggling 1,0,1,0…: exactly 8 writes spread over 15 cycles, addresses contiguous 0..7, data only from we_in=1 cycles.
- Abort at count=3 → no further bram_we, state IDLE, done=0, count=3. A subsequent arm edge restarts from addr 0.
- Arm held high through DONE → no restart. Arm low then high → new capture, done cleared in the arm cycle.
- Reset asserted during CAPTURE → bram_we, status_out and busy go to 0 asynchronously. After release, the block is in IDLE and ignores an already-high arm bit until it falls and rises again.
